spi_ram_responder: RTL and testbench



---
 rtl/spi_ram_pkg.sv | 21 ++
 rtl/spi_in_sync.sv | 39 +++
 rtl/spi_ram_responder.sv | 193 +++++++++++++++++++
 tb/tb_spi_ram_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI serial-RAM responder.
//   CMD_READ / CMD_WRITE : recognised command bytes
//   state_t              : protocol state of the responder
//   BIT_CNT_W            : width of the bit-within-byte counter
package spi_ram_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam int BIT_CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD,
        WR,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronizer for one asynchronous input bit, followed by a
// previous-value register so edges can be detected in the clk domain.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : raw asynchronous input
//   level      : synchronized level
//   rise, fall : single-clk pulses on synchronized 0->1 / 1->0 transitions
// RST_VAL sets the idle level so that leaving reset never looks like an edge.
module spi_in_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 responder modelling a small byte-addressed serial SRAM.
// Everything runs in the clk domain; the SPI pins are oversampled.
// Supports READ (0x03) and WRITE (0x02) with one address byte and
// sequential auto-increment that wraps modulo DEPTH.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   spi_cs_n     : chip select, active low
//   spi_sck      : serial clock (mode 0, idles low, at most clk/8)
//   spi_mosi     : master-out data, MSB first
//   spi_miso     : master-in data, MSB first, 0 when not driving
//   spi_miso_oe  : high only while read data is being shifted out
//   selected     : synchronized, inverted chip select
//   cmd_err      : one-clk pulse when an unknown command byte completes
module spi_ram_responder
    import spi_ram_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int INIT_ZERO = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_cs_n,
    input  logic spi_sck,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic selected,
    output logic cmd_err
);

    logic cs_n_s, cs_rise, cs_fall;
    logic sck_level_unused, sck_rise, sck_fall;
    logic mosi_meta, mosi_s;

    spi_in_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_cs_n),
        .level (cs_n_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_in_sync #(.RST_VAL(1'b0)) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_sck),
        .level (sck_level_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // mosi has the same two-flop latency as sck, so on the clk where
    // sck_rise is seen, mosi_s holds the bit the master set up before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_meta <= spi_mosi;
            mosi_s    <= mosi_meta;
        end
    end

    state_t               state, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           rx_shift;
    logic [7:0]           tx_shift;
    logic [ADDR_W-1:0]    addr;
    logic                 cmd_is_read;
    logic                 miso_oe_q;
    logic                 cmd_err_q;
    logic                 cmd_bad;

    logic [7:0]           mem [DEPTH];

    logic                 shifting;
    logic                 bit_rise;
    logic                 byte_done;
    logic [7:0]           rx_byte;
    logic [ADDR_W-1:0]    addr_inc;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 tx_load;
    logic                 mem_we;

    // A cs_n rise in the same clk as an sck rise wins: the bit is dropped.
    assign shifting  = (state == CMD) || (state == ADDR) || (state == RD) || (state == WR);
    assign bit_rise  = sck_rise && shifting && !cs_rise;
    assign byte_done = bit_rise && (&bit_cnt);
    assign rx_byte   = {rx_shift[6:0], mosi_s};
    assign addr_inc  = addr + ADDR_W'(1);
    assign rd_addr   = (state == ADDR) ? rx_byte[ADDR_W-1:0] : addr_inc;
    assign tx_load   = byte_done && ((state == ADDR) ? cmd_is_read : (state == RD));
    assign mem_we    = byte_done && (state == WR);

    always_comb begin
        state_d = state;
        cmd_bad = 1'b0;
        if (cs_rise) begin
            state_d = IDLE;
        end else if (cs_fall) begin
            state_d = CMD;
        end else begin
            case (state)
                CMD: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
                            state_d = ADDR;
                        end else begin
                            state_d = IGNORE;
                            cmd_bad = 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (byte_done) begin
                        state_d = cmd_is_read ? RD : WR;
                    end
                end
                default: state_d = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            addr        <= '0;
            cmd_is_read <= 1'b0;
            miso_oe_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state     <= state_d;
            cmd_err_q <= cmd_bad;
            miso_oe_q <= (state_d == RD);

            if (cs_fall) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (bit_rise) begin
                bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                rx_shift <= rx_byte;
            end

            if (byte_done && state == CMD) begin
                cmd_is_read <= (rx_byte == CMD_READ);
            end

            if (byte_done && state == ADDR) begin
                addr <= rx_byte[ADDR_W-1:0];
            end else if (byte_done && (state == RD || state == WR)) begin
                addr <= addr_inc;
            end

            // The fall right after a byte-completing rise sees bit_cnt == 0;
            // skipping that shift keeps the freshly loaded bit 7 on miso.
            if (tx_load) begin
                tx_shift <= mem[rd_addr];
            end else if (state == RD && sck_fall && !cs_rise && bit_cnt != '0) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    generate
        if (INIT_ZERO != 0) begin : g_mem_clear
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= '0;
                    end
                end else if (mem_we) begin
                    mem[addr] <= rx_byte;
                end
            end
        end else begin : g_mem_keep
            always_ff @(posedge clk) begin
                if (mem_we) begin
                    mem[addr] <= rx_byte;
                end
            end
        end
    endgenerate

    assign spi_miso    = miso_oe_q & tx_shift[7];
    assign spi_miso_oe = miso_oe_q;
    assign selected    = ~cs_n_s;
    assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Self-checking bench for spi_ram_responder: acts as an SPI mode-0 master
// (sck = clk/8) and compares read data against a byte-array memory model.
module tb_spi_ram_responder;

    localparam int         DEPTH = 32;
    localparam int         HALF  = 4;
    localparam logic [7:0] RD_C  = 8'h03;
    localparam logic [7:0] WR_C  = 8'h02;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_sck = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_miso, spi_miso_oe, spi_selected, spi_cmd_err;

    spi_ram_responder #(.DEPTH(DEPTH), .ADDR_W(5), .INIT_ZERO(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_cs_n    (spi_cs_n),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .selected    (spi_selected),
        .cmd_err     (spi_cmd_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_mem [DEPTH];
    logic [7:0] wbuf [8];
    logic [7:0] rbuf [8];
    logic       rd_oe_ok;
    logic       rd_sel;

    int err_cnt = 0, err_run = 0, err_maxrun = 0, oe_cnt = 0;

    always @(posedge clk) begin
        if (spi_cmd_err === 1'b1) begin
            err_cnt = err_cnt + 1;
            err_run = err_run + 1;
            if (err_run > err_maxrun) err_maxrun = err_run;
        end else begin
            err_run = 0;
        end
        if (spi_miso_oe === 1'b1) oe_cnt = oe_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic spi_byte(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic oe_ok);
        rx = 8'h00;
        oe_ok = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx[7-i] = spi_miso;
            if (spi_miso_oe !== 1'b1) oe_ok = 1'b0;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2*HALF) @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input int n);
        logic [7:0] r;
        logic ok;
        cs_begin();
        spi_byte(WR_C, 8, r, ok);
        spi_byte(a, 8, r, ok);
        for (int i = 0; i < n; i++) begin
            spi_byte(wbuf[i], 8, r, ok);
            model_mem[(int'(a) + i) % DEPTH] = wbuf[i];
        end
        cs_end();
    endtask

    task automatic do_read(input logic [7:0] a, input int n);
        logic [7:0] r;
        logic ok;
        rd_oe_ok = 1'b1;
        cs_begin();
        rd_sel = spi_selected;
        spi_byte(RD_C, 8, r, ok);
        spi_byte(a, 8, r, ok);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, 8, r, ok);
            rbuf[i] = r;
            if (!ok) rd_oe_ok = 1'b0;
        end
        cs_end();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
        n_checks++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe); end
        n_checks++; if (spi_selected !== 1'b0) begin n_fail++; $display("FAIL reset_selected: got %b want 0", spi_selected); end
        n_checks++; if (spi_cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err: got %b want 0", spi_cmd_err); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_read_after_reset();
        int e0;
        e0 = err_cnt;
        do_read(8'h00, 1);
        n_checks++; if (rbuf[0] !== 8'h00) begin n_fail++; $display("FAIL read0_data: got %h want 00", rbuf[0]); end
        n_checks++; if (rd_oe_ok !== 1'b1) begin n_fail++; $display("FAIL read0_oe: got %b want 1", rd_oe_ok); end
        n_checks++; if (rd_sel !== 1'b1) begin n_fail++; $display("FAIL read0_selected: got %b want 1", rd_sel); end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL read0_cmd_err: got %0d pulses want 0", err_cnt - e0); end
        n_checks++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL read0_oe_after: got %b want 0", spi_miso_oe); end
    endtask

    task automatic test_write_read();
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        do_write(8'h04, 2);
        do_read(8'h04, 2);
        n_checks++; if (rbuf[0] !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_b0: got %h want a5", rbuf[0]); end
        n_checks++; if (rbuf[1] !== 8'h3C) begin n_fail++; $display("FAIL wr_rd_b1: got %h want 3c", rbuf[1]); end
        n_checks++; if (rd_oe_ok !== 1'b1) begin n_fail++; $display("FAIL wr_rd_oe: got %b want 1", rd_oe_ok); end
    endtask

    task automatic test_wrap();
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(8'h1F, 2);
        do_read(8'h1F, 2);
        n_checks++; if (rbuf[0] !== 8'h11) begin n_fail++; $display("FAIL wrap_b0: got %h want 11", rbuf[0]); end
        n_checks++; if (rbuf[1] !== 8'h22) begin n_fail++; $display("FAIL wrap_b1: got %h want 22", rbuf[1]); end
        do_read(8'h00, 1);
        n_checks++; if (rbuf[0] !== 8'h22) begin n_fail++; $display("FAIL wrap_addr0: got %h want 22", rbuf[0]); end
    endtask

    task automatic test_bad_cmd();
        int e0, o0;
        logic [7:0] r;
        logic ok;
        e0 = err_cnt;
        o0 = oe_cnt;
        cs_begin();
        spi_byte(8'h9F, 8, r, ok);
        spi_byte(8'h03, 8, r, ok);
        spi_byte(8'h04, 8, r, ok);
        spi_byte(8'hFF, 8, r, ok);
        cs_end();
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL badcmd_pulses: got %0d want 1", err_cnt - e0); end
        n_checks++; if (err_maxrun !== 1) begin n_fail++; $display("FAIL badcmd_width: got %0d clk want 1", err_maxrun); end
        n_checks++; if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL badcmd_oe: got %0d oe clks want 0", oe_cnt - o0); end
        do_read(8'h04, 1);
        n_checks++; if (rbuf[0] !== model_mem[4]) begin n_fail++; $display("FAIL badcmd_next_read: got %h want %h", rbuf[0], model_mem[4]); end
    endtask

    task automatic test_partial_write();
        logic [7:0] r;
        logic ok;
        cs_begin();
        spi_byte(WR_C, 8, r, ok);
        spi_byte(8'h08, 8, r, ok);
        spi_byte(8'h77, 8, r, ok);
        spi_byte(8'hFF, 5, r, ok);
        cs_end();
        model_mem[8] = 8'h77;
        do_read(8'h08, 2);
        n_checks++; if (rbuf[0] !== 8'h77) begin n_fail++; $display("FAIL partial_b0: got %h want 77", rbuf[0]); end
        n_checks++; if (rbuf[1] !== 8'h00) begin n_fail++; $display("FAIL partial_b1: got %h want 00", rbuf[1]); end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        logic ok;
        cs_begin();
        spi_byte(RD_C, 8, r, ok);
        spi_byte(8'h04, 8, r, ok);
        spi_byte(8'h00, 3, r, ok);
        n_checks++; if (spi_miso_oe !== 1'b1) begin n_fail++; $display("FAIL abort_oe_before: got %b want 1", spi_miso_oe); end
        spi_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL abort_oe: got %b want 0", spi_miso_oe); end
        n_checks++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL abort_miso: got %b want 0", spi_miso); end
        repeat (2*HALF) @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] a;
        int n;
        for (int it = 0; it < 16; it++) begin
            a = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(a, n);
            a = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            do_read(a, n);
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (rbuf[i] !== model_mem[(int'(a) + i) % DEPTH]) begin
                    n_fail++;
                    $display("FAIL rand_read it=%0d addr=%h idx=%0d: got %h want %h",
                             it, a, i, rbuf[i], model_mem[(int'(a) + i) % DEPTH]);
                end
            end
            n_checks++; if (rd_oe_ok !== 1'b1) begin n_fail++; $display("FAIL rand_oe it=%0d: got %b want 1", it, rd_oe_ok); end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] r;
        logic ok;
        cs_begin();
        spi_byte(RD_C, 8, r, ok);
        spi_byte(8'h04, 8, r, ok);
        spi_byte(8'h00, 3, r, ok);
        n_checks++; if (spi_miso_oe !== 1'b1) begin n_fail++; $display("FAIL rstmid_oe_before: got %b want 1", spi_miso_oe); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_oe: got %b want 0", spi_miso_oe); end
        n_checks++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso: got %b want 0", spi_miso); end
        n_checks++; if (spi_selected !== 1'b0) begin n_fail++; $display("FAIL rstmid_selected: got %b want 0", spi_selected); end
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        do_read(8'h04, 2);
        n_checks++; if (rbuf[0] !== 8'h00) begin n_fail++; $display("FAIL rstmid_clear_b0: got %h want 00", rbuf[0]); end
        n_checks++; if (rbuf[1] !== 8'h00) begin n_fail++; $display("FAIL rstmid_clear_b1: got %h want 00", rbuf[1]); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_wrap();
        test_bad_cmd();
        test_partial_write();
        test_abort();
        test_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
